ahb_lite_nslave_ic: RTL

Parametrised single-master AHB-Lite interconnect: decodes the master address phase onto NUM_SLAVES memory-mapped slaves and multiplexes the data-phase response back to the master. It is the generalised successor of the fixed two-slave interconnect between the Cortex-M0 master and the memory controller / external slave. It adds three things:
- an internal default slave that returns two-cycle ERROR for unmapped accesses;
- a sticky error-capture register;
- a saturating error counter.

---
 rtl/ahb_lite_nslave_ic.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ahb_lite_nslave_ic.sv
// Single-master AHB-Lite interconnect: address decode onto NUM_SLAVES slaves,
// data-phase response mux, built-in ERROR default slave and error capture/count.
module ahb_lite_nslave_ic #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hE000_0000}}
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [3:0]                   HPROT,
  input  logic                         HMASTLOCK,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic [ADDR_W-1:0]            HADDR_S,
  output logic [1:0]                   HTRANS_S,
  output logic                         HWRITE_S,
  output logic [2:0]                   HSIZE_S,
  output logic [2:0]                   HBURST_S,
  output logic [3:0]                   HPROT_S,
  output logic                         HMASTLOCK_S,
  output logic [DATA_W-1:0]            HWDATA_S,
  output logic                         HREADY_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic                         err_clr,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [3:0]                   err_src,
  output logic                         err_write,
  output logic [7:0]                   err_count
);

  // dsel codes: 0..NUM_SLAVES-1 real slaves, NUM_SLAVES default slave, 15 no data phase
  localparam logic [3:0] DEF_SEL  = 4'(NUM_SLAVES);
  localparam logic [3:0] NONE_SEL = 4'hF;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  ds_state_t         ds_state, ds_next;
  logic [3:0]        dsel, dec_idx;
  logic              hit_any, unmapped_req, err_done;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;

  assign HADDR_S     = HADDR;
  assign HTRANS_S    = HTRANS;
  assign HWRITE_S    = HWRITE;
  assign HSIZE_S     = HSIZE;
  assign HBURST_S    = HBURST;
  assign HPROT_S     = HPROT;
  assign HMASTLOCK_S = HMASTLOCK;
  assign HWDATA_S    = HWDATA;
  assign HREADY_S    = HREADY;

  // Scanning downwards lets the lowest matching index win on overlaps
  always_comb begin
    hit_any = 1'b0;
    dec_idx = DEF_SEL;
    HSEL_S  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit_any = 1'b1;
        dec_idx = 4'(i);
      end
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL_S[i] = hit_any && (dec_idx == 4'(i));
    end
  end

  assign unmapped_req = HTRANS[1] && !hit_any;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (dsel == DEF_SEL) begin
      HREADY = (ds_state != DS_ERR1);
      HRESP  = (ds_state != DS_IDLE);
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dsel == 4'(i)) begin
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
          HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE: if (HREADY && unmapped_req) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = unmapped_req ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_state <= DS_IDLE;
    else          ds_state <= ds_next;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel    <= NONE_SEL;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else if (HREADY) begin
      dsel    <= HTRANS[1] ? dec_idx : NONE_SEL;
      addr_q  <= HADDR;
      write_q <= HWRITE;
    end
  end

  // Only the final (HREADY high) cycle of a two-cycle ERROR counts as a completion
  assign err_done = HREADY && HRESP && (dsel != NONE_SEL);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_src   <= '0;
      err_write <= 1'b0;
      err_count <= '0;
    end else if (err_done) begin
      if (!err_valid || err_clr) begin
        err_valid <= 1'b1;
        err_addr  <= addr_q;
        err_src   <= dsel;
        err_write <= write_q;
      end
      if (err_clr)                 err_count <= 8'd1;
      else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_count <= '0;
    end
  end

endmodule
